// File: rtl/hdc_pkg.sv
// Shared definitions for the hyperdimensional classifier datapath.
// Contents:
//   - default geometry of the class-hypervector store
//   - helpers deriving frame count and index widths from that geometry
//   - state encoding of the class-hypervector streaming FSM
package hdc_pkg;

    localparam int HV_DIM_DEF      = 192;
    localparam int FRAME_W_DEF     = 64;
    localparam int NUM_CLASSES_DEF = 8;

    // Frames per hypervector. HV_DIM is expected to be a multiple of FRAME_W.
    function automatic int frames_per_vec(input int hv_dim, input int frame_w);
        return hv_dim / frame_w;
    endfunction

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/hvec_frame_ram.sv
// Frame storage for the class-hypervector store.
// One synchronous write port, one combinational read port, and an
// asynchronous clear of every entry.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low clear of the whole array
//   wr_en    write strobe (address assumed in range)
//   wr_addr  write entry index
//   wr_data  write payload
//   rd_addr  read entry index
//   rd_data  combinational read payload
module hvec_frame_ram #(
    parameter int DEPTH  = 24,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/class_hvec_store.sv
// Writable class-hypervector store.
// Streams one class, or every class in sweep mode, frame by frame over a
// valid/ready interface, and accepts frame writes at any time.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_en, wr_class, wr_frame, wr_data   frame write port
//   req_valid, req_ready, req_sweep, req_class   read request handshake
//   out_valid, out_ready             output frame handshake
//   out_data, out_class, out_frame   presented frame and its position
//   out_last_frame                   presented frame is the last of its vector
//   out_last                         presented frame ends the transaction
//   err                              one-cycle pulse per illegal request/write
module class_hvec_store
    import hdc_pkg::*;
#(
    parameter int NUM_CLASSES   = NUM_CLASSES_DEF,
    parameter int HV_DIM        = HV_DIM_DEF,
    parameter int FRAME_W       = FRAME_W_DEF,
    localparam int NUM_FRAMES   = frames_per_vec(HV_DIM, FRAME_W),
    localparam int CLASS_W      = idx_width(NUM_CLASSES),
    localparam int FIDX_W       = idx_width(NUM_FRAMES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CLASS_W-1:0] wr_class,
    input  logic [FIDX_W-1:0]  wr_frame,
    input  logic [FRAME_W-1:0] wr_data,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_sweep,
    input  logic [CLASS_W-1:0] req_class,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic [CLASS_W-1:0] out_class,
    output logic [FIDX_W-1:0]  out_frame,
    output logic               out_last_frame,
    output logic               out_last,
    output logic               err
);

    localparam int DEPTH  = NUM_CLASSES * NUM_FRAMES;
    localparam int ADDR_W = idx_width(DEPTH);
    localparam logic [FIDX_W-1:0]  LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    stream_state_t state, state_nx;

    logic               sweep_mode;
    logic               req_legal, wr_legal;
    logic               req_fire, out_fire, load_en;
    logic [CLASS_W-1:0] ld_class;
    logic [FIDX_W-1:0]  ld_frame;
    logic               ld_sweep, ld_last;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [FRAME_W-1:0] rd_data, ld_data;

    assign req_legal = req_sweep || (int'(req_class) < NUM_CLASSES);
    assign wr_legal  = (int'(wr_class) < NUM_CLASSES) && (int'(wr_frame) < NUM_FRAMES);
    assign req_fire  = req_valid && req_ready;
    assign out_fire  = out_valid && out_ready;
    // The final frame's handshake ends the transaction, so nothing is reloaded.
    assign load_en   = (req_fire && req_legal) || (out_fire && !out_last);

    hvec_frame_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (FRAME_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && wr_legal),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Position of the frame to load into the output register next.
    always_comb begin
        ld_class = out_class;
        ld_frame = out_frame;
        ld_sweep = sweep_mode;
        if (state == IDLE) begin
            ld_sweep = req_sweep;
            ld_frame = '0;
            // Illegal class never loads; pin it to 0 to keep the read in range.
            ld_class = (req_sweep || !req_legal) ? '0 : req_class;
        end else if (out_frame == LAST_FRAME) begin
            ld_frame = '0;
            if (sweep_mode) begin
                ld_class = out_class + 1'b1;
            end
        end else begin
            ld_frame = out_frame + 1'b1;
        end
    end

    assign ld_last = (ld_frame == LAST_FRAME) && (!ld_sweep || (ld_class == LAST_CLASS));
    assign wr_addr = ADDR_W'(int'(wr_class) * NUM_FRAMES + int'(wr_frame));
    assign rd_addr = ADDR_W'(int'(ld_class) * NUM_FRAMES + int'(ld_frame));
    // A write landing on the frame being loaded this edge wins over stored data.
    assign ld_data = (wr_en && wr_legal && (wr_addr == rd_addr)) ? wr_data : rd_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_fire && req_legal) state_nx = STREAM;
            STREAM:  if (out_fire && out_last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = rst_n && (state == IDLE);
        out_valid = (state == STREAM);
    end

    // Output register: a snapshot taken when a frame is loaded, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data       <= '0;
            out_class      <= '0;
            out_frame      <= '0;
            out_last_frame <= 1'b0;
            out_last       <= 1'b0;
            sweep_mode     <= 1'b0;
            err            <= 1'b0;
        end else begin
            err <= (wr_en && !wr_legal) || (req_fire && !req_legal);
            if (load_en) begin
                out_data       <= ld_data;
                out_class      <= ld_class;
                out_frame      <= ld_frame;
                out_last_frame <= (ld_frame == LAST_FRAME);
                out_last       <= ld_last;
                sweep_mode     <= ld_sweep;
            end
        end
    end

endmodule

// File: tb/tb_class_hvec_store.sv
// Bench for class_hvec_store: scoreboard of expected frames pushed when a
// request is issued and popped as the store delivers frames.
module tb_class_hvec_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, req_valid, req_ready, req_sweep;
    logic [2:0]  wr_class, req_class, out_class;
    logic [1:0]  wr_frame, out_frame;
    logic [63:0] wr_data, out_data;
    logic        out_valid, out_ready, out_last_frame, out_last, err;

    // second store with a class count that is not a power of two
    logic        b_wr_en, b_req_valid, b_req_ready, b_req_sweep;
    logic [2:0]  b_wr_class, b_req_class, b_out_class;
    logic [1:0]  b_wr_frame, b_out_frame;
    logic [63:0] b_wr_data, b_out_data;
    logic        b_out_valid, b_out_ready, b_out_last_frame, b_out_last, b_err;

    always #5 clk = ~clk;

    class_hvec_store dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_class(wr_class), .wr_frame(wr_frame), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_sweep(req_sweep), .req_class(req_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_class(out_class), .out_frame(out_frame),
        .out_last_frame(out_last_frame), .out_last(out_last), .err(err)
    );

    class_hvec_store #(.NUM_CLASSES(6), .HV_DIM(192), .FRAME_W(64)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_class(b_wr_class), .wr_frame(b_wr_frame), .wr_data(b_wr_data),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sweep(b_req_sweep), .req_class(b_req_class),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_class(b_out_class), .out_frame(b_out_frame),
        .out_last_frame(b_out_last_frame), .out_last(b_out_last), .err(b_err)
    );

    typedef struct {
        logic [63:0] data;
        logic [2:0]  cls;
        logic [1:0]  frm;
        logic        lf;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_mem [8][3];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_class(input int c, input bit sweep_last);
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            e.data = model_mem[c][f];
            e.cls  = 3'(c);
            e.frm  = 2'(f);
            e.lf   = (f == 2);
            e.last = sweep_last && (f == 2);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_sweep();
        for (int c = 0; c < 8; c++) push_class(c, c == 7);
    endtask

    task automatic request(input logic sw, input logic [2:0] c);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_sweep = sw;
        req_class = c;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("req_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Drain the current transaction; toggle=1 applies the ready pattern 1,0,0,1.
    task automatic run_stream(input bit toggle);
        int n;
        n = 0;
        while (out_valid && n < 300) begin
            out_ready = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (out_valid) chk("stream_timeout", 64'd1, 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wr(input logic [2:0] c, input logic [1:0] f, input logic [63:0] d);
        wr_en = 1'b1;
        wr_class = c;
        wr_frame = f;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (f < 2'd3) model_mem[c][f] = d;
    endtask

    // Output monitor: compares delivered frames and checks stall stability.
    initial begin : monitor
        exp_t e;
        exp_t held;
        bit   held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on && rst_n) begin
                if (held_v) begin
                    chk("hold_data",  out_data,       held.data);
                    chk("hold_class", 64'(out_class), 64'(held.cls));
                    chk("hold_frame", 64'(out_frame), 64'(held.frm));
                    chk("hold_last",  64'(out_last),  64'(held.last));
                end
                held_v = 1'b0;
                if (out_valid) begin
                    chk("req_ready_busy", 64'(req_ready), 64'd0);
                    if (out_ready) begin
                        if (sb_q.size() == 0) begin
                            chk("extra_frame", 64'd1, 64'd0);
                        end else begin
                            e = sb_q.pop_front();
                            chk("data",       out_data,            e.data);
                            chk("class",      64'(out_class),      64'(e.cls));
                            chk("frame",      64'(out_frame),      64'(e.frm));
                            chk("last_frame", 64'(out_last_frame), 64'(e.lf));
                            chk("last",       64'(out_last),       64'(e.last));
                        end
                    end else begin
                        held_v    = 1'b1;
                        held.data = out_data;
                        held.cls  = out_class;
                        held.frm  = out_frame;
                        held.last = out_last;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_n = 1'b0;
        wr_en = 1'b0; wr_class = '0; wr_frame = '0; wr_data = '0;
        req_valid = 1'b0; req_sweep = 1'b0; req_class = '0; out_ready = 1'b1;
        b_wr_en = 1'b0; b_wr_class = '0; b_wr_frame = '0; b_wr_data = '0;
        b_req_valid = 1'b0; b_req_sweep = 1'b0; b_req_class = '0; b_out_ready = 1'b1;
        for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) model_mem[c][f] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_data",  out_data,       64'd0);
        chk("rst_err",   64'(err),       64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 64'(req_ready), 64'd1);
        mon_on = 1'b1;

        // single read of an unwritten class
        push_class(3, 1'b1);
        request(1'b0, 3'd3);
        run_stream(1'b0);
        chk("err_quiet", 64'(err), 64'd0);

        // write class 5 and read it back
        wr(3'd5, 2'd0, 64'h0123456789ABCDEF);
        wr(3'd5, 2'd1, ~64'h0123456789ABCDEF);
        wr(3'd5, 2'd2, 64'hFFFF0000FFFF0000);
        chk("err_legal_wr", 64'(err), 64'd0);
        push_class(5, 1'b1);
        request(1'b0, 3'd5);
        run_stream(1'b0);

        // sweep over all classes at full rate
        wr(3'd7, 2'd2, 64'h7777_0000_0000_0002);
        push_sweep();
        request(1'b1, 3'd4);
        run_stream(1'b0);

        // class 5 again under backpressure
        push_class(5, 1'b1);
        request(1'b0, 3'd5);
        run_stream(1'b1);

        // writes while stalled on frame 0 of class 2
        model_mem[2][1] = 64'hDEAD;
        push_class(2, 1'b1);
        out_ready = 1'b0;
        request(1'b0, 3'd2);
        wr(3'd2, 2'd0, 64'hDEAD);
        wr(3'd2, 2'd1, 64'hDEAD);
        run_stream(1'b0);

        // write in the same cycle its frame is loaded
        model_mem[4][1] = 64'hF0F0_1234_5678_0F0F;
        push_class(4, 1'b1);
        out_ready = 1'b0;
        request(1'b0, 3'd4);
        tick();
        wr_en = 1'b1; wr_class = 3'd4; wr_frame = 2'd1; wr_data = 64'hF0F0_1234_5678_0F0F;
        out_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        run_stream(1'b0);

        // illegal frame index: dropped with an error pulse
        wr(3'd0, 2'd3, 64'hBAD0_BAD0_BAD0_BAD0);
        chk("err_wr_frame", 64'(err), 64'd1);
        tick();
        chk("err_wr_clear", 64'(err), 64'd0);
        push_class(1, 1'b1);
        request(1'b0, 3'd1);
        run_stream(1'b0);

        // illegal class on the six-class store
        b_req_valid = 1'b1; b_req_sweep = 1'b0; b_req_class = 3'd7;
        chk("b_ready", 64'(b_req_ready), 64'd1);
        tick();
        b_req_valid = 1'b0;
        chk("b_err_req",   64'(b_err),       64'd1);
        chk("b_no_valid",  64'(b_out_valid), 64'd0);
        tick();
        chk("b_err_clear", 64'(b_err),       64'd0);
        chk("b_idle",      64'(b_out_valid), 64'd0);
        b_wr_en = 1'b1; b_wr_class = 3'd6; b_wr_frame = 2'd0; b_wr_data = 64'h1;
        tick();
        b_wr_en = 1'b0;
        chk("b_err_wr", 64'(b_err), 64'd1);

        // reset in the middle of a sweep
        for (int c = 0; c < 8; c++) wr(3'(c), 2'd1, 64'hA5A5_0000_0000_0000 | 64'(c));
        push_sweep();
        request(1'b1, 3'd0);
        out_ready = 1'b1;
        repeat (5) tick();
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        chk("midrst_data",  out_data,       64'd0);
        sb_q.delete();
        for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) model_mem[c][f] = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_err",   64'(err),       64'd0);
        mon_on = 1'b1;
        push_sweep();
        request(1'b1, 3'd0);
        run_stream(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
